// File: rtl/inst_fetch_buf_pkg.sv
// rtl/inst_fetch_buf_pkg.sv - shared types and constants for the instruction fetch buffer
package inst_fetch_buf_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  // Fetch sequencer states: no request, request whose word is kept, request whose word is thrown away.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One queued instruction: PC in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are word addresses; the byte offset is dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// rtl/inst_fetch_buf_fetch_fifo.sv - synchronous FIFO of {pc, inst} entries with clear
module fetch_fifo
  import inst_fetch_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointer/count bookkeeping and entry storage; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - sequential instruction prefetcher with flush redirect and decode-side FIFO
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [PC_W-1:0] r_fpc;
  logic [PC_W-1:0] w_fpc_next;
  logic            r_mem_req;
  logic [PC_W-1:0] r_mem_addr;
  logic [PC_W-1:0] w_addr_next;

  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_next;
  logic            w_room;
  logic [PC_W-1:0] w_flush_pc;
  logic [PC_W-1:0] w_fpc_inc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // An ack only means something while a request is actually on the bus.
  assign w_ack        = mem_ack & r_mem_req;
  assign w_flush_pc   = align_pc(flush_pc);
  assign w_fpc_inc    = r_fpc + PC_STEP;
  assign w_push       = (r_state == ST_REQ) && w_ack && !flush;
  assign w_pop        = inst_valid && inst_ready && !flush;
  assign w_count_next = flush ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  assign w_room       = (w_count_next < CW'(DEPTH));
  assign w_push_entry = '{pc: r_fpc, inst: mem_rdata};

  // Next fetch state, fetch pointer and bus address; flush outranks everything else.
  always_comb begin
    w_state_next = r_state;
    w_fpc_next   = r_fpc;
    w_addr_next  = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_fpc_next   = w_flush_pc;
          w_addr_next  = w_flush_pc;
          w_state_next = ST_REQ;
        end else if (w_room) begin
          w_addr_next  = r_fpc;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush && w_ack) begin
          // Returning word belongs to the old stream; start the redirect right away.
          w_fpc_next   = w_flush_pc;
          w_addr_next  = w_flush_pc;
          w_state_next = ST_REQ;
        end else if (flush) begin
          // Request must still complete on the bus; its word will be dropped.
          w_fpc_next   = w_flush_pc;
          w_state_next = ST_DRAIN;
        end else if (w_ack) begin
          w_fpc_next = w_fpc_inc;
          if (w_room) begin
            w_addr_next = w_fpc_inc;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (w_ack) begin
          w_fpc_next   = flush ? w_flush_pc : r_fpc;
          w_addr_next  = flush ? w_flush_pc : r_fpc;
          w_state_next = ST_REQ;
        end else if (flush) begin
          w_fpc_next = w_flush_pc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Fetch sequencer registers; mem_req follows the next state so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fpc      <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fpc      <= w_fpc_next;
      r_mem_req  <= (w_state_next != ST_IDLE);
      r_mem_addr <= w_addr_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (flush),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inst_valid = (w_count != '0);
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - randomized self-checking bench for inst_fetch_buf
module tb_inst_fetch_buf;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_buf #(
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: random or held wait states, checks the request stays put until acked.
  int          left = -1;
  bit          hold = 1'b0;
  int          max_wait = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_rst = 1'b0;

  always @(negedge clk) begin
    if (prev_req && !mem_ack && prev_rst && rst) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_held", mem_addr, prev_addr);
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_rst  = rst;
    if (mem_ack || !mem_req) left = -1;
    mem_ack = 1'b0;
    if (mem_req && !hold) begin
      if (left < 0) left = $urandom_range(max_wait, 0);
      if (left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        left--;
      end
    end
  end

  // Decode-side model: the delivered stream is consecutive words from the last redirect point.
  logic [31:0] exp_pc = RST_PC;
  int          since_pop = 0;

  task automatic tick();
    bit fl;
    fl = flush;
    if (!rst) begin
      exp_pc = RST_PC;
    end else if (flush) begin
      exp_pc = {flush_pc[31:2], 2'b00};
    end else if (inst_valid && inst_ready) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_inst", inst, mem_word(exp_pc));
      exp_pc    = exp_pc + 32'd4;
      since_pop = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (fl && rst) chk("flush_empty", 32'(inst_valid), 32'd0);
    since_pop++;
  endtask

  task automatic restart();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, RST_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    tick();

    // Zero-wait streaming: one fetch and one delivery per cycle.
    max_wait   = 0;
    inst_ready = 1'b1;
    rst        = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("seq_req", 32'(mem_req), 32'd1);
      chk("seq_addr", mem_addr, RST_PC + 32'(4 * (k - 1)));
      if (k >= 2) begin
        chk("seq_valid", 32'(inst_valid), 32'd1);
        chk("seq_pc", inst_pc, RST_PC + 32'(4 * (k - 2)));
      end
    end

    // Stalled decode: FIFO fills, requests stop, one pop restarts fetch at 0x10.
    inst_ready = 1'b0;
    restart();
    for (int k = 0; k < 5; k++) tick();
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_pc", inst_pc, RST_PC);
    inst_ready = 1'b1;
    tick();
    chk("resume_req", 32'(mem_req), 32'd1);
    chk("resume_addr", mem_addr, RST_PC + 32'h10);

    // Flush with a full FIFO and nothing in flight.
    inst_ready = 1'b0;
    restart();
    for (int k = 0; k < 5; k++) tick();
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    chk("idle_fl_req", 32'(mem_req), 32'd1);
    chk("idle_fl_addr", mem_addr, 32'h100);
    inst_ready = 1'b1;
    tick();
    chk("idle_fl_valid", 32'(inst_valid), 32'd1);
    chk("idle_fl_pc", inst_pc, 32'h100);
    for (int k = 0; k < 3; k++) tick();

    // Flush while the fetch of 0x8 is stalled; its word must be discarded.
    restart();
    tick();
    tick();
    hold = 1'b1;
    tick();
    chk("drain_pre_addr", mem_addr, 32'h8);
    flush    = 1'b1;
    flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("drain_req", 32'(mem_req), 32'd1);
    chk("drain_addr", mem_addr, 32'h8);
    tick();
    tick();
    hold = 1'b0;
    tick();
    tick();
    chk("drain_redirect", mem_addr, 32'h200);
    chk("drain_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) tick();

    // Flush coinciding with an ack, unaligned target.
    flush    = 1'b1;
    flush_pc = 32'h103;
    tick();
    flush = 1'b0;
    chk("ackfl_req", 32'(mem_req), 32'd1);
    chk("ackfl_addr", mem_addr, 32'h100);
    for (int k = 0; k < 3; k++) tick();

    // Fetch pointer wraps from the top of the address space to zero.
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Reset mid-request with two entries queued.
    inst_ready = 1'b0;
    restart();
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_addr", mem_addr, RST_PC);
    tick();
    rst        = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("midrst_restart_req", 32'(mem_req), 32'd1);
    chk("midrst_restart_addr", mem_addr, RST_PC);

    // Random traffic: wait states, decode back-pressure and redirects.
    since_pop = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15, 0) == 0) max_wait = $urandom_range(3, 0);
      inst_ready = ($urandom_range(3, 0) != 0);
      flush      = ($urandom_range(19, 0) == 0);
      if ($urandom_range(3, 0) == 0) flush_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      else flush_pc = $urandom;
      tick();
      if (since_pop > 300) begin
        chk("liveness", 32'(since_pop), 32'd0);
        since_pop = 0;
      end
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
